pixel_serial_source: RTL and testbench

- Image-memory responder that feeds the Sobel/filter engine (`main`) its bit-serial `pixel_in` stream.
- Holds one image of up to 16x16 pixels, loaded over a parallel write port.
- On each read request for a `Pixel_address`, returns the addressed pixel MSB-first on `pixel_in`, one bit per `clk`, with `validData` framing the bits.
- Sits between the frame loader and the filter engine's pixel-fetch interface.

---
 rtl/img_pkg.sv | 32 +++
 rtl/pixel_ram.sv | 37 +++
 rtl/pixel_serial_source.sv | 122 ++++++++++++
 tb/tb_pixel_serial_source.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
// Module      : img_pkg
// Description : Shared types and constants for the serial pixel source.
// Revision    : 1.0 - initial release
// ============================================================================
package img_pkg;

  localparam int PIXEL_W_DEFAULT = 8;
  localparam int ADDR_W_DEFAULT  = 8;

  localparam logic [1:0] SZ_4  = 2'b00;
  localparam logic [1:0] SZ_8  = 2'b01;
  localparam logic [1:0] SZ_16 = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // Number of valid pixels for an image size; the reserved code maps to 16x16.
  function automatic int unsigned pixel_count(input logic [1:0] size);
    case (size)
      SZ_4:    pixel_count = 16;
      SZ_8:    pixel_count = 64;
      default: pixel_count = 256;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_ram.sv
`default_nettype none
// ============================================================================
// Module      : pixel_ram
// Description : Image store, one write port, one read-first synchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_ram
  import img_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEFAULT,
  parameter int ADDR_W  = ADDR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [PIXEL_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [PIXEL_W-1:0] r_mem [DEPTH];

  // Read and write share the edge, so a colliding read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= r_mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_serial_source.sv
`default_nettype none
// ============================================================================
// Module      : pixel_serial_source
// Description : Serves one requested pixel MSB-first on pixel_in per request.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_serial_source
  import img_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEFAULT,
  parameter int ADDR_W  = ADDR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         size,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  Pixel_address,
  output logic               validData,
  output logic               pixel_in,
  output logic               busy,
  output logic               addr_err
);

  localparam int               CNT_W      = (PIXEL_W > 1) ? $clog2(PIXEL_W) : 1;
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(PIXEL_W - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [PIXEL_W-1:0] r_shreg;
  logic [PIXEL_W-1:0] w_rd_data;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_accept;
  logic               w_out_of_range;

  assign w_accept       = (r_state == IDLE) && rd_req;
  assign w_out_of_range = 32'(r_addr) >= pixel_count(size);

  // The RAM read is launched on the accepting edge so its word is ready in FETCH.
  pixel_ram #(
    .PIXEL_W (PIXEL_W),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (w_accept),
    .rd_addr (Pixel_address),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    validData    = 1'b0;
    busy         = 1'b0;
    addr_err     = 1'b0;
    pixel_in     = 1'b0;
    case (r_state)
      IDLE: begin
        if (rd_req) begin
          w_state_next = FETCH;
        end
      end
      FETCH: begin
        busy         = 1'b1;
        addr_err     = w_out_of_range;
        w_state_next = SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        validData = 1'b1;
        pixel_in  = r_shreg[PIXEL_W-1];
        if (r_cnt == c_last_bit) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (rd_req) begin
            r_addr <= Pixel_address;
          end
        end
        FETCH: begin
          r_shreg <= w_out_of_range ? '0 : w_rd_data;
          r_cnt   <= '0;
        end
        SHIFT: begin
          r_shreg <= r_shreg << 1;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_serial_source.sv
`default_nettype none
// Directed scenarios plus random traffic, checked against a cycle timeline
// built from the request-to-burst latency rules and a shadow image memory.
module tb_pixel_serial_source;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] size;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] Pixel_address;
  logic       validData;
  logic       pixel_in;
  logic       busy;
  logic       addr_err;

  always #5 clk = ~clk;

  pixel_serial_source #(
    .PIXEL_W (8),
    .ADDR_W  (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .size          (size),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_req        (rd_req),
    .Pixel_address (Pixel_address),
    .validData     (validData),
    .pixel_in      (pixel_in),
    .busy          (busy),
    .addr_err      (addr_err)
  );

  localparam int MAXC = 8192;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  bit         ev    [MAXC];
  bit         eb    [MAXC];
  bit         ebusy [MAXC];
  logic [7:0] mem_m [256];
  int         free_at  = 0;
  int         fetch_iv = -1;
  int         fetch_addr = 0;
  logic [7:0] cap_val = '0;
  bit         fetch_err = 1'b0;
  bit         obs_v, obs_b, obs_e;
  int         lead;

  function automatic int count_of(input logic [1:0] s);
    if (s == 2'b00) return 16;
    if (s == 2'b01) return 64;
    return 256;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic compare();
    bit e_err;
    e_err = (fetch_iv == cyc) && (fetch_addr >= count_of(size));
    if (fetch_iv == cyc) fetch_err = e_err;
    chk("validData", {31'd0, validData}, {31'd0, ev[cyc]});
    chk("pixel_in",  {31'd0, pixel_in},  {31'd0, ev[cyc] & eb[cyc]});
    chk("busy",      {31'd0, busy},      {31'd0, ebusy[cyc]});
    chk("addr_err",  {31'd0, addr_err},  {31'd0, e_err});
    obs_v = validData;
    obs_b = pixel_in;
    obs_e = addr_err;
  endtask

  // Request accepted at edge t: FETCH in cycle t, bits in cycles t+1..t+8,
  // next request honoured from edge t+10 on.
  task automatic model_edge();
    logic [7:0] val;
    if (!rst && fetch_iv == cyc - 1) begin
      val = fetch_err ? 8'h00 : cap_val;
      for (int k = 0; k < 8; k++) begin
        ev[cyc+k] = 1'b1;
        eb[cyc+k] = val[7-k];
      end
    end
    if (!rst && rd_req && cyc >= free_at) begin
      cap_val    = mem_m[Pixel_address];
      fetch_iv   = cyc;
      fetch_addr = int'(Pixel_address);
      for (int k = 0; k <= 8; k++) ebusy[cyc+k] = 1'b1;
      free_at = cyc + 10;
    end
    if (wr_en) mem_m[wr_addr] = wr_data;
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    rd_req        = 1'b0;
    Pixel_address = '0;
  endtask

  task automatic write(input logic [7:0] a, input logic [7:0] d);
    drive_idle();
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    cycle();
    drive_idle();
  endtask

  task automatic async_reset();
    drive_idle();
    #2 rst = 1'b1;
    #1;
    chk("rst_validData", {31'd0, validData}, 32'd0);
    chk("rst_pixel_in",  {31'd0, pixel_in},  32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_addr_err",  {31'd0, addr_err},  32'd0);
    for (int k = cyc; k < cyc + 12; k++) begin
      ev[k]    = 1'b0;
      ebusy[k] = 1'b0;
    end
    fetch_iv = -1;
    free_at  = 0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic req_collect(input logic [7:0] a, input logic [7:0] expv, input string tag,
                             input bit want_err, input int inj, output int lead_o);
    logic [7:0] acc;
    int         n;
    bit         errs;
    acc = '0;
    n   = 0;
    drive_idle();
    rd_req        = 1'b1;
    Pixel_address = a;
    cycle();
    drive_idle();
    lead_o = obs_v ? 0 : 1;
    errs   = obs_e;
    for (int i = 0; i < 24 && n < 8; i++) begin
      if (i == inj) begin
        rd_req        = 1'b1;
        Pixel_address = 8'd7;
        wr_en         = 1'b1;
        wr_addr       = 8'd5;
        wr_data       = 8'h00;
      end
      cycle();
      drive_idle();
      if (obs_e) errs = 1'b1;
      if (obs_v) begin
        acc = {acc[6:0], obs_b};
        n++;
      end else if (n == 0) begin
        lead_o++;
      end
    end
    chk({tag, "_bits"}, {24'd0, acc}, {24'd0, expv});
    chk({tag, "_nbits"}, n, 8);
    chk({tag, "_err"}, {31'd0, errs}, {31'd0, want_err});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst  = 1'b1;
    size = 2'b00;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_validData", {31'd0, validData}, 32'd0);
    chk("reset_pixel_in",  {31'd0, pixel_in},  32'd0);
    chk("reset_busy",      {31'd0, busy},      32'd0);
    chk("reset_addr_err",  {31'd0, addr_err},  32'd0);
    rst = 1'b0;

    for (int a = 0; a < 256; a++) write(8'(a), 8'($urandom));
    write(8'd5, 8'hB2);
    write(8'd15, 8'hFF);
    write(8'd200, 8'h5A);

    // Basic burst; lead of 2 = request cycle + FETCH before the first bit.
    size = 2'b01;
    req_collect(8'd5, 8'hB2, "t1", 1'b0, -1, lead);
    chk("t1_lead", lead, 2);
    repeat (3) cycle();

    size = 2'b00;
    req_collect(8'd16, 8'h00, "t2_oob", 1'b1, -1, lead);
    repeat (2) cycle();
    req_collect(8'd15, 8'hFF, "t2_edge", 1'b0, -1, lead);
    repeat (2) cycle();

    // Mid-burst request and write to the in-flight address.
    size = 2'b01;
    req_collect(8'd5, 8'hB2, "t3", 1'b0, 3, lead);
    repeat (12) cycle();
    write(8'd5, 8'hB2);

    // Reset during the fourth bit.
    drive_idle();
    rd_req        = 1'b1;
    Pixel_address = 8'd5;
    cycle();
    drive_idle();
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      cycle();
      if (obs_v) n++;
    end
    chk("t4_bits_before_rst", n, 3);
    async_reset();
    repeat (2) cycle();
    req_collect(8'd5, 8'hB2, "t4_after", 1'b0, -1, lead);

    // Back-to-back: second request in the cycle right after the last bit.
    repeat (3) cycle();
    req_collect(8'd5, 8'hB2, "t5a", 1'b0, -1, lead);
    req_collect(8'd15, 8'hFF, "t5b", 1'b0, -1, lead);
    chk("t5_gap", lead, 2);
    repeat (2) cycle();

    size = 2'b11;
    req_collect(8'd200, 8'h5A, "t6", 1'b0, -1, lead);
    repeat (3) cycle();

    for (int i = 0; i < 1500; i++) begin
      drive_idle();
      if ($urandom_range(0, 15) == 0) size = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        wr_en   = 1'b1;
        wr_addr = 8'($urandom);
        wr_data = 8'($urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        rd_req        = 1'b1;
        Pixel_address = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, count_of(size) - 1))
                                                    : 8'($urandom);
      end
      if ($urandom_range(0, 299) == 0) async_reset();
      else cycle();
    end
    drive_idle();
    repeat (12) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
